// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI command/response engine: state encoding,
// frame/timing constants and the CRC7 generator polynomial.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    TRAIL,
    DONE
  } state_t;

  localparam int unsigned FRAME_LEN  = 48;
  localparam int unsigned NCR_MAX    = 64;
  localparam int unsigned NRC_CYCLES = 8;
  localparam int unsigned R1_LEN     = 8;
  localparam int unsigned R37_LEN    = 40;

  localparam logic [39:0] TIMEOUT_RESP = 40'hFF_FFFF_FFFF;
  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [6:0]  CRC7_POLY    = 7'h09;

  // CMD8 (R7) and CMD58 (R3) carry a 32-bit payload after R1
  function automatic logic isLongResp(input logic [5:0] idx);
    return (idx == 6'd8) || (idx == 6'd58);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7+x^3+1, zero seed) over the first 40 bits of a
// command frame, MSB first.
module sd_crc7
  import sd_pkg::*;
(
  input  logic [39:0] data,
  output logic [6:0]  crc
);

  always_comb begin
    crc = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (data[39 - i] ^ crc[6]) crc = {crc[5:0], 1'b0} ^ CRC7_POLY;
      else                       crc = {crc[5:0], 1'b0};
    end
  end

endmodule

// File: rtl/sd_cmd_rp.sv
// SD SPI-mode command sender and response receiver: shifts out a 48-bit
// command frame, waits for the card's R1 start bit and captures R1/R3/R7.
module sd_cmd_rp
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  index,
  input  logic [31:0] argument,
  input  logic        isStart,
  output logic        isBusy,
  output logic        isFinish,
  output logic        DI,
  input  logic        DO,
  output logic [39:0] response
);

  state_t      state, nextState;
  logic [5:0]  idxLat;
  logic [31:0] argLat;
  logic [6:0]  cnt;
  logic [38:0] rxShift;
  logic [6:0]  crc;
  logic [47:0] frame;
  logic        longResp;

  sd_crc7 uCrc (
    .data ({2'b01, idxLat, argLat}),
    .crc  (crc)
  );

  assign frame    = {2'b01, idxLat, argLat, crc, 1'b1};
  assign longResp = isLongResp(idxLat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (isStart) nextState = SEND;
      SEND:    if (cnt == '0) nextState = WAIT;
      WAIT: begin
        if (!DO)                               nextState = RECV;
        else if (cnt == 7'(NCR_MAX - 1))      nextState = TRAIL;
      end
      RECV:    if (cnt == 7'd1) nextState = TRAIL;
      TRAIL:   if (cnt == 7'(NRC_CYCLES - 1)) nextState = DONE;
      DONE:    if (!isStart) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    DI       = 1'b1;
    isBusy   = 1'b0;
    isFinish = 1'b0;
    unique case (state)
      SEND: begin
        DI     = frame[cnt[5:0]];
        isBusy = 1'b1;
      end
      WAIT, RECV, TRAIL: isBusy = 1'b1;
      DONE:              isFinish = 1'b1;
      default: ;
    endcase
  end

  // cnt is reused: SEND bit index (down), WAIT Ncr (up), RECV bits left (down), TRAIL Nrc (up)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idxLat   <= '0;
      argLat   <= '0;
      cnt      <= '0;
      rxShift  <= '0;
      response <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (isStart) begin
            idxLat <= index;
            argLat <= argument;
            cnt    <= 7'(FRAME_LEN - 1);
          end
        end
        SEND: cnt <= (cnt == '0) ? '0 : cnt - 7'd1;
        WAIT: begin
          if (!DO) begin
            // the start bit is the response MSB and is always 0, so clearing suffices
            rxShift <= '0;
            cnt     <= longResp ? 7'(R37_LEN - 1) : 7'(R1_LEN - 1);
          end else if (cnt == 7'(NCR_MAX - 1)) begin
            response <= TIMEOUT_RESP;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        RECV: begin
          rxShift <= {rxShift[37:0], DO};
          if (cnt == 7'd1) begin
            response <= longResp ? {rxShift, DO} : {32'h0, rxShift[6:0], DO};
            cnt      <= '0;
          end else begin
            cnt <= cnt - 7'd1;
          end
        end
        TRAIL: cnt <= (cnt == 7'(NRC_CYCLES - 1)) ? '0 : cnt + 7'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_rp.sv
// Self-checking bench for sd_cmd_rp: directed SD commands plus randomized
// commands against a frame/response model built from polynomial division.
module tb_sd_cmd_rp;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  index;
  logic [31:0] argument;
  logic        isStart;
  logic        isBusy;
  logic        isFinish;
  logic        DI;
  logic        DO;
  logic [39:0] response;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [39:0] respModel;

  sd_cmd_rp dut (
    .clk      (clk),
    .reset    (reset),
    .index    (index),
    .argument (argument),
    .isStart  (isStart),
    .isBusy   (isBusy),
    .isFinish (isFinish),
    .DI       (DI),
    .DO       (DO),
    .response (response)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Remainder of m(x)*x^7 divided by x^7+x^3+1 via long division
  function automatic logic [6:0] crc7Ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] frameRef(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7Ref({2'b01, idx, arg}), 1'b1};
  endfunction

  // One full transaction; card answers val (len bits, MSB first) after delay ones,
  // or never answers when timeout is set.
  task automatic runCmd(input logic [5:0] idx, input logic [31:0] arg, input int unsigned delay,
                        input logic [39:0] val, input bit timeout, input bit holdStart,
                        input bit checkFrameConst, input logic [47:0] frameConst);
    logic [47:0] cap;
    logic [47:0] expFrame;
    logic [39:0] prev;
    logic [39:0] expResp;
    int unsigned len, nOnes, total, n;
    prev     = respModel;
    expFrame = frameRef(idx, arg);
    len      = (idx == 6'd8 || idx == 6'd58) ? 40 : 8;
    @(negedge clk);
    index = idx; argument = arg; isStart = 1'b1; DO = 1'b1;
    @(negedge clk);
    if (!holdStart) isStart = 1'b0;
    index = 6'($urandom); argument = $urandom;
    check("busy_send", 48'(isBusy), 48'd1);
    cap[47] = DI;
    for (int k = 46; k >= 0; k--) begin
      @(negedge clk);
      cap[k] = DI;
      if (k == 20) check("resp_held_send", 48'(response), 48'(prev));
    end
    check("frame", cap, expFrame);
    if (checkFrameConst) check("frame_const", cap, frameConst);
    nOnes = timeout ? 64 : delay;
    total = timeout ? 64 : delay + len;
    @(negedge clk);
    for (int unsigned j = 0; j < total; j++) begin
      if (j > 0) @(negedge clk);
      DO = (j < nOnes) ? 1'b1 : val[len - 1 - (j - nOnes)];
    end
    n = 0;
    do begin
      @(negedge clk);
      DO = 1'b1;
      n++;
    end while (!isFinish && n < 30);
    check("trail_latency", 48'(n), 48'd9);
    expResp   = timeout ? 40'hFF_FFFF_FFFF : (len == 40 ? val : {32'h0, val[7:0]});
    respModel = expResp;
    check("done_finish", 48'(isFinish), 48'd1);
    check("done_busy", 48'(isBusy), 48'd0);
    check("done_di", 48'(DI), 48'd1);
    check("response", 48'(response), 48'(expResp));
    if (holdStart) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("hold_no_retrigger", {46'd0, isFinish, isBusy}, 48'b10);
      end
      isStart = 1'b0;
    end
    @(negedge clk);
    check("idle_after_done", {46'd0, isFinish, isBusy}, 48'b00);
  endtask

  initial begin
    logic [5:0]  rIdx;
    logic [31:0] rArg;
    logic [39:0] rVal;
    bit          rTo;
    reset = 1'b1; isStart = 1'b0; DO = 1'b1; index = '0; argument = '0;
    respModel = '0;
    #3;
    check("reset_di", 48'(DI), 48'd1);
    check("reset_busy", 48'(isBusy), 48'd0);
    check("reset_finish", 48'(isFinish), 48'd0);
    check("reset_resp", 48'(response), 48'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    runCmd(6'd0,  32'h0,         16, 40'h01,            1'b0, 1'b0, 1'b1, 48'h40_0000_0000_95);
    runCmd(6'd8,  32'h0000_01AA, 3,  40'h01_0000_01AA,  1'b0, 1'b0, 1'b1, 48'h48_0000_01AA_87);
    runCmd(6'd58, 32'h0,         0,  40'h00_C0FF_8000,  1'b0, 1'b0, 1'b0, 48'h0);
    runCmd(6'd55, 32'h0,         0,  40'h0,             1'b1, 1'b1, 1'b0, 48'h0);
    runCmd(6'd17, 32'hDEAD_BEEF, 5,  40'h05,            1'b0, 1'b0, 1'b0, 48'h0);

    // Abort mid-frame: reset lands while bit 20 is on DI
    @(negedge clk);
    index = 6'd17; argument = 32'h1234_5678; isStart = 1'b1;
    @(negedge clk);
    isStart = 1'b0;
    for (int k = 46; k >= 20; k--) @(negedge clk);
    check("abort_bit20", 48'(DI), 48'(frameRef(6'd17, 32'h1234_5678) >> 20) & 48'd1);
    reset = 1'b1;
    #1;
    check("abort_di", 48'(DI), 48'd1);
    check("abort_busy", 48'(isBusy), 48'd0);
    check("abort_finish", 48'(isFinish), 48'd0);
    check("abort_resp", 48'(response), 48'd0);
    respModel = '0;
    @(negedge clk);
    reset = 1'b0;
    runCmd(6'd17, 32'h1234_5678, 2,  40'h00,            1'b0, 1'b0, 1'b0, 48'h0);

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 2) == 0) rIdx = ($urandom_range(0, 1) == 0) ? 6'd8 : 6'd58;
      else                           rIdx = 6'($urandom);
      rArg = $urandom;
      rVal = {$urandom, 8'($urandom)};
      if (rIdx == 6'd8 || rIdx == 6'd58) rVal[39] = 1'b0;
      else                               rVal = {32'h0, 1'b0, rVal[6:0]};
      rTo = ($urandom_range(0, 4) == 0);
      runCmd(rIdx, rArg, $urandom_range(0, 62), rVal, rTo, 1'(t % 2), 1'b0, 48'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
